// File: rtl/nzet_pkg.sv
// Shared definitions for the 2:4 sparse MAC: width defaults, stage-2 state encoding
// and the accumulator saturation helper.
package nzet_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 8;

    // Wide enough to carry any legal accumulator sum before clamping.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] val;
    } sat_t;

    // Clamp a sign-extended sum into the signed acc_w range and flag any clipping.
    function automatic sat_t sat_clamp(input logic signed [SAT_W-1:0] sum, input int acc_w);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_t                    r;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (acc_w - 1));
        if (sum > max_v) begin
            r.val = max_v;
            r.ovf = 1'b1;
        end else if (sum < min_v) begin
            r.val = min_v;
            r.ovf = 1'b1;
        end else begin
            r.val = sum;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nzet_dual_mult.sv
// Stage 1 of the sparse MAC: registered two-term signed multiply-add of the
// selected activations with their compressed weights.
module nzet_dual_mult
    import nzet_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int P_W    = 2 * DATA_W + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] a_0,
    input  logic signed [DATA_W-1:0] a_1,
    input  logic signed [DATA_W-1:0] w_0,
    input  logic signed [DATA_W-1:0] w_1,
    input  logic                     in_last,
    output logic signed [P_W-1:0]    p,
    output logic                     p_valid,
    output logic                     p_last
);

    logic signed [P_W-1:0] prod;

    // Widen before multiplying: (-128*-128)*2 = 32768 only fits in P_W bits.
    always_comb begin
        prod = P_W'(a_0) * P_W'(w_0) + P_W'(a_1) * P_W'(w_1);
    end

    // NOTE: en low freezes every register, so a stalled beat is held, not dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else if (en) begin
            p_valid <= load;
            if (load) begin
                p      <= prod;
                p_last <= in_last;
            end
        end
    end

endmodule

// File: rtl/nzet_sparse_mac.sv
// Sparse PE dot-product unit: accumulates dual products per beat and emits the
// saturated result, beat count and overflow flag over a valid/ready handshake.
module nzet_sparse_mac
    import nzet_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] ain_0,
    input  logic signed [DATA_W-1:0] ain_1,
    input  logic signed [DATA_W-1:0] w_0,
    input  logic signed [DATA_W-1:0] w_1,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         out_beats
);

    localparam int P_W   = 2 * DATA_W + 1;
    localparam int SUM_W = ((ACC_W > P_W) ? ACC_W : P_W) + 1;

    logic                    stall;
    logic                    accept;
    logic                    adv;
    logic signed [P_W-1:0]   p;
    logic                    p_valid;
    logic                    p_last;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    ovf;
    logic signed [SUM_W-1:0] sum;
    sat_t                    sat;
    logic signed [ACC_W-1:0] clamped;
    logic                    new_ovf;
    state_t                  state;
    state_t                  state_nxt;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign adv      = p_valid && !stall;

    nzet_dual_mult #(
        .DATA_W (DATA_W),
        .P_W    (P_W)
    ) u_dual_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (!stall),
        .load    (accept),
        .a_0     (ain_0),
        .a_1     (ain_1),
        .w_0     (w_0),
        .w_1     (w_1),
        .in_last (in_last),
        .p       (p),
        .p_valid (p_valid),
        .p_last  (p_last)
    );

    always_comb begin
        sum     = SUM_W'(acc) + SUM_W'(p);
        sat     = sat_clamp(SAT_W'(sum), ACC_W);
        clamped = sat.val[ACC_W-1:0];
        new_ovf = sat.ovf;
        cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    end

    // Stage-2 state; out_valid is simply "a result is held".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ACC: begin
                if (adv) state_nxt = p_last ? S_OUT : S_ACC;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (p_valid) state_nxt = p_last ? S_OUT : S_ACC;
                    else         state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign out_valid = (state == S_OUT);

    // A last beat finishes the result and restarts the accumulator in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            if (p_last) begin
                out_data  <= clamped;
                out_beats <= cnt_inc;
                out_ovf   <= ovf | new_ovf;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else begin
                acc <= clamped;
                cnt <= cnt_inc;
                ovf <= ovf | new_ovf;
            end
        end
    end

endmodule

// File: tb/tb_nzet_sparse_mac.sv
// Scoreboard bench for nzet_sparse_mac at ACC_W=16 so saturation is reachable
// with 8-bit operands.
module tb_nzet_sparse_mac;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] ain_0;
    logic signed [DATA_W-1:0] ain_1;
    logic signed [DATA_W-1:0] w_0;
    logic signed [DATA_W-1:0] w_1;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_ovf;
    logic [CNT_W-1:0]         out_beats;

    typedef struct {
        logic signed [ACC_W-1:0] data;
        logic                    ovf;
        logic [CNT_W-1:0]        beats;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_hs  = 0;

    always #5 clk = ~clk;

    nzet_sparse_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain_0     (ain_0),
        .ain_1     (ain_1),
        .w_0       (w_0),
        .w_1       (w_1),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_beats (out_beats)
    );

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_res(input int data, input logic ovf, input int beats);
        exp_t e;
        e.data  = ACC_W'(data);
        e.ovf   = ovf;
        e.beats = CNT_W'(beats);
        sb.push_back(e);
    endtask

    // Starts at a negedge, holds the beat until accepted, returns at the next negedge.
    task automatic send(input int a0, input int a1, input int b0, input int b1, input logic last);
        logic rdy;
        logic accepted;
        accepted = 1'b0;
        ain_0    = DATA_W'(a0);
        ain_1    = DATA_W'(a1);
        w_0      = DATA_W'(b0);
        w_1      = DATA_W'(b1);
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #3;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready never rose, got 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        ain_0    = '0;
        ain_1    = '0;
        w_0      = '0;
        w_1      = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_pending", sb.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: samples just before the edge on which a handshake would complete.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) begin
                n_hs++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got data %0d, expected no result", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_ovf", out_ovf, e.ovf);
                    check("out_beats", out_beats, e.beats);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int hs0;
        idle();
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_beats", out_beats, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat: 3*5 + -2*7 = 1; result appears one edge after the accepting edge.
        expect_res(1, 1'b0, 1);
        send(3, -2, 5, 7, 1'b1);
        idle();
        #1 check("lat_after_accept", out_valid, 0);
        @(negedge clk);
        #1 check("lat_after_stage2", out_valid, 1);
        drain();

        // Three beats: 4 + 12 - 2 = 14.
        expect_res(14, 1'b0, 3);
        send(1, 1, 2, 2, 1'b0);
        send(4, 0, 3, 9, 1'b0);
        send(-1, -1, 1, 1, 1'b1);
        idle();
        drain();

        // All-zero selector beats still count.
        expect_res(25, 1'b0, 3);
        send(0, 0, 0, 0, 1'b0);
        send(0, 0, 0, 0, 1'b0);
        send(5, 0, 5, 0, 1'b1);
        idle();
        drain();

        // Positive saturation: 3 x 32768 clamps to 32767; next result starts clean.
        expect_res(32767, 1'b1, 3);
        for (int i = 0; i < 3; i++) send(-128, -128, -128, -128, (i == 2));
        expect_res(1, 1'b0, 1);
        send(1, 0, 1, 0, 1'b1);
        // Negative saturation: 3 x -32512 clamps to -32768.
        expect_res(-32768, 1'b1, 3);
        for (int i = 0; i < 3; i++) send(-128, -128, 127, 127, (i == 2));
        // Two-term sum of 32768 alone must survive stage 1 before clamping.
        expect_res(32767, 1'b1, 1);
        send(-128, -128, -128, -128, 1'b1);
        idle();
        drain();

        // Beat counter saturates at 255.
        expect_res(1, 1'b0, 255);
        for (int i = 0; i < 299; i++) send(0, 0, 0, 0, 1'b0);
        send(1, 0, 1, 0, 1'b1);
        idle();
        drain();

        // Backpressure: A (23) held, B (-7) waits in stage 1, C (100) waits upstream.
        out_ready = 1'b0;
        expect_res(23, 1'b0, 1);
        send(2, 3, 4, 5, 1'b1);
        expect_res(-7, 1'b0, 1);
        send(-1, 2, 3, -2, 1'b1);
        expect_res(100, 1'b0, 1);
        fork
            send(10, 0, 10, 0, 1'b1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    #2;
                    check("bp_in_ready", in_ready, 0);
                    check("bp_out_valid", out_valid, 1);
                    check("bp_hold_data", out_data, 23);
                end
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Back-to-back: four single-beat results, no bubbles.
        hs0 = n_hs;
        expect_res(1, 1'b0, 1);
        send(1, 0, 1, 0, 1'b1);
        expect_res(4, 1'b0, 1);
        send(2, 0, 2, 0, 1'b1);
        expect_res(9, 1'b0, 1);
        send(3, 0, 3, 0, 1'b1);
        expect_res(-16, 1'b0, 1);
        send(-4, 0, 4, 0, 1'b1);
        idle();
        #1 check("b2b_valid_a", out_valid, 1);
        @(negedge clk);
        #1 check("b2b_valid_b", out_valid, 1);
        @(negedge clk);
        #1 check("b2b_valid_end", out_valid, 0);
        check("b2b_handshakes", n_hs - hs0, 4);
        drain();

        // Reset mid-accumulation discards the partial sum.
        send(1, 1, 1, 1, 1'b0);
        send(2, 2, 2, 2, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_ovf", out_ovf, 0);
        check("midrst_out_beats", out_beats, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_res(6, 1'b0, 1);
        send(2, 0, 3, 0, 1'b1);
        idle();
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
